// File: rtl/table_pkg.sv
// Shared types and helpers for the multi-port register table.
// Holds the index width calculation, flush FSM states and port slice offsets.
package table_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_t;

   localparam int unsigned DEF_TABLE_SIZE   = 32;
   localparam int unsigned DEF_DATA_WIDTH   = 8;
   localparam int unsigned DEF_INPUT_RATE   = 2;
   localparam int unsigned DEF_OUTPUT_RATE  = 2;
   localparam int unsigned DEF_READ_LATENCY = 1;
   localparam int unsigned DEF_WRITE_FIRST  = 1;

   function automatic int unsigned idx_w(input int unsigned size);
      int unsigned w;
      w = $clog2(size);
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

   // Low bit of port p inside a flattened per-port bus of the given field width.
   function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/table_mp_if.sv
// Bus between a table client (master) and table_mp (slave).
// Per-port fields are flattened with port p at [p*W +: W].
interface table_mp_if
#(
   parameter int unsigned TABLE_SIZE  = 32,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned INPUT_RATE  = 2,
   parameter int unsigned OUTPUT_RATE = 2
);
   import table_pkg::*;

   localparam int unsigned IW = idx_w(TABLE_SIZE);

   logic [INPUT_RATE-1:0]             wr_en;
   logic [INPUT_RATE*IW-1:0]          index_wr;
   logic [INPUT_RATE*DATA_WIDTH-1:0]  data_wr;
   logic [OUTPUT_RATE-1:0]            rd_en;
   logic [OUTPUT_RATE*IW-1:0]         index_rd;
   logic [OUTPUT_RATE*DATA_WIDTH-1:0] data_rd;
   logic [OUTPUT_RATE-1:0]            rd_valid;
   logic [OUTPUT_RATE-1:0]            rd_hit;
   logic                              flush_req;
   logic                              busy;

   modport master (
      output wr_en, index_wr, data_wr, rd_en, index_rd, flush_req,
      input  data_rd, rd_valid, rd_hit, busy
   );

   modport slave (
      input  wr_en, index_wr, data_wr, rd_en, index_rd, flush_req,
      output data_rd, rd_valid, rd_hit, busy
   );

endinterface

// File: rtl/table_rd_pipe.sv
// Per-port read output register chain, 1 or 2 stages deep.
// Data and hit hold their last value between accepted reads; valid is a pulse.
module table_rd_pipe
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  hit_i,
   output logic                  vld_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  hit_o
);

   logic                  s1_vld_q;
   logic [DATA_WIDTH-1:0] s1_data_q;
   logic                  s1_hit_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
         s1_hit_q  <= 1'b0;
      end else begin
         s1_vld_q <= vld_i;
         if (vld_i) begin
            s1_data_q <= data_i;
            s1_hit_q  <= hit_i;
         end
      end
   end

   if (READ_LATENCY >= 2) begin : g_two
      logic                  s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_data_q;
      logic                  s2_hit_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s2_vld_q  <= 1'b0;
            s2_data_q <= '0;
            s2_hit_q  <= 1'b0;
         end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
               s2_data_q <= s1_data_q;
               s2_hit_q  <= s1_hit_q;
            end
         end
      end

      assign vld_o  = s2_vld_q;
      assign data_o = s2_data_q;
      assign hit_o  = s2_hit_q;
   end else begin : g_one
      assign vld_o  = s1_vld_q;
      assign data_o = s1_data_q;
      assign hit_o  = s1_hit_q;
   end

endmodule

// File: rtl/table_mp.sv
// Multi-port register table with per-entry valid bits, prioritised writes,
// selectable write-first/read-first bypass and a sequential flush engine.
module table_mp
   import table_pkg::*;
#(
   parameter int unsigned TABLE_SIZE   = DEF_TABLE_SIZE,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned INPUT_RATE   = DEF_INPUT_RATE,
   parameter int unsigned OUTPUT_RATE  = DEF_OUTPUT_RATE,
   parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
   parameter int unsigned WRITE_FIRST  = DEF_WRITE_FIRST
) (
   input logic       clk,
   input logic       rst,
   table_mp_if.slave bus
);

   localparam int unsigned IW = idx_w(TABLE_SIZE);

   logic [DATA_WIDTH-1:0]  mem_q [TABLE_SIZE];
   logic [DATA_WIDTH-1:0]  mem_d [TABLE_SIZE];
   logic [TABLE_SIZE-1:0]  valid_q, valid_d;
   flush_state_t           state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic                   accept;

   logic [DATA_WIDTH-1:0]  rdata [OUTPUT_RATE];
   logic [OUTPUT_RATE-1:0] rhit;
   logic [OUTPUT_RATE-1:0] rvld;

   function automatic logic in_range(input logic [IW-1:0] idx);
      return 32'(idx) < TABLE_SIZE;
   endfunction

   assign accept   = (state_q == IDLE);
   assign bus.busy = (state_q == FLUSH);

   // Ascending port order lets the highest-numbered writer win; the flush
   // clear comes last but never overlaps a write since writes need IDLE.
   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      for (int unsigned p = 0; p < INPUT_RATE; p++) begin
         if (accept && bus.wr_en[p] && in_range(bus.index_wr[slice_lo(p, IW) +: IW])) begin
            mem_d[bus.index_wr[slice_lo(p, IW) +: IW]]   = bus.data_wr[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
            valid_d[bus.index_wr[slice_lo(p, IW) +: IW]] = 1'b1;
         end
      end
      if (state_q == FLUSH) begin
         mem_d[ptr_q]   = '0;
         valid_d[ptr_q] = 1'b0;
      end
   end

   always_comb begin
      for (int unsigned q = 0; q < OUTPUT_RATE; q++) begin
         rdata[q] = '0;
         rhit[q]  = 1'b0;
         rvld[q]  = accept && bus.rd_en[q];
         if (in_range(bus.index_rd[slice_lo(q, IW) +: IW])) begin
            if (WRITE_FIRST != 0) begin
               rdata[q] = mem_d[bus.index_rd[slice_lo(q, IW) +: IW]];
               rhit[q]  = valid_d[bus.index_rd[slice_lo(q, IW) +: IW]];
            end else begin
               rdata[q] = mem_q[bus.index_rd[slice_lo(q, IW) +: IW]];
               rhit[q]  = valid_q[bus.index_rd[slice_lo(q, IW) +: IW]];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (bus.flush_req) state_d = FLUSH;
         end
         FLUSH: begin
            if (ptr_q == IW'(TABLE_SIZE - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + IW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < TABLE_SIZE; i++) mem_q[i] <= '0;
         valid_q <= '0;
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   for (genvar q = 0; q < OUTPUT_RATE; q++) begin : g_rd
      table_rd_pipe #(
         .DATA_WIDTH   (DATA_WIDTH),
         .READ_LATENCY (READ_LATENCY)
      ) u_rd_pipe (
         .clk    (clk),
         .rst    (rst),
         .vld_i  (rvld[q]),
         .data_i (rdata[q]),
         .hit_i  (rhit[q]),
         .vld_o  (bus.rd_valid[q]),
         .data_o (bus.data_rd[q*DATA_WIDTH +: DATA_WIDTH]),
         .hit_o  (bus.rd_hit[q])
      );
   end

endmodule
